mem_port_req_sequencer: RTL and testbench
=========================================

Name: mem_port_req_sequencer

Overview:
- Upstream request stage for one port of the multi-bank latency memory top.
- Accepts read/write requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues requests to the memory port's en/we/addr/din inputs, stalling any read that would hit an in-flight write.
- Captures read data after the configured read latency and returns it with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, width of request write data and memory data.
- ADDR_WIDTH, 6, address width (64-deep memory).
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.
- RD_LATENCY, 2, edges from memory sampling a read to valid dout; ≥1.
- WR_LATENCY, 2, edges from memory sampling a write to it being readable; ≥1.

Ports:
- clka  in  1  clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH).
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_WIDTH  request address.
- i_req_data  in  DATA_WIDTH  write data (ignored for reads).
- o_mem_en  out  1  memory port enable.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_din  out  DATA_WIDTH  memory write data.
- i_mem_dout  in  DATA_WIDTH  memory read data.
- o_rd_valid  out  1  one-cycle read-return pulse.
- o_rd_data  out  DATA_WIDTH  returned read data.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_busy  out  1  any request queued, issuing, in the read pipe, or inside a write window.

Behaviour:
- Reset (async assert, sync deassert use):
  - FIFO, issue register, read-return pipe and write-history cleared.
  - All outputs 0, except o_req_ready = 1.
  - Reset mid-operation drops all queued and in-flight work; o_rd_valid never pulses for a read issued before reset.
- Accept: push on an edge with i_req_valid && o_req_ready. No bypass; a full FIFO deasserts ready. Push and pop on the same edge are allowed when not full; count is unchanged.
- Issue register:
  - Loads the FIFO head (pops) on an edge when the FIFO is non-empty and there is no hazard.
  - Otherwise it loads a bubble (o_mem_en = 0) on that edge.
  - o_mem_* are driven directly from the issue register. The memory samples them on the following edge (the issue edge T).
  - Minimum latency: accepted at edge N into an empty FIFO → loaded at N+1 → sampled by memory at N+2.
  - Throughput: one request per cycle.
- Hazard rule:
  - A read to address A whose memory sample edge would be T_r stalls at the FIFO head if any write to A has sample edge T_w with 0 < T_r − T_w < WR_LATENCY.
  - This includes a write currently in the issue register.
  - Write history is a WR_LATENCY-deep shift register of {valid, addr}.
  - WR_LATENCY = 1 → no stalls.
  - Writes never stall. Requests issue in order; a stalled head blocks everything behind it.
- Read return:
  - A read with issue edge T sets o_rd_valid = 1 and o_rd_data = i_mem_dout sampled at edge T+RD_LATENCY.
  - Both are registered and held for one cycle.
  - o_rd_data holds its last value when o_rd_valid = 0.
  - Implemented as a RD_LATENCY-deep valid shift register; back-to-back reads give back-to-back pulses.
- o_busy = (count≠0) | issue valid | any read-pipe bit | any write-history bit.

Test Plan:
- Reset, then idle → o_req_ready=1, o_mem_en=0, o_rd_valid=0, o_fifo_count=0, o_busy=0.
- Write A=5 D=0xA5 accepted edge 1, read A=5 accepted edge 2 (defaults) → write sampled edge 3; read stalled one cycle, sampled edge 5 (not 4); o_rd_valid pulses after edge 7 with 0xA5.
- 4 writes with o_mem_en forced idle by a held hazard, then a 5th request → o_fifo_count=4, o_req_ready=0, 5th not accepted; ready returns after the first pop.
- Reads to addresses 1,2,3 on consecutive edges (no hazard) → sampled edges N+2..N+4; o_rd_valid high three consecutive cycles, data in order.
- Write A=7, then read A=8 → no stall; read sampled one edge after the write.
- Assert i_rst one cycle after a read issues → all outputs reset immediately; no o_rd_valid afterwards; o_req_ready=1 after release.

Source files
------------

// File: rtl/mem_port_req_sequencer.sv
// Request sequencer for one memory port: queues requests, issues them in order,
// holds back reads that would hit an in-flight write, and returns read data.
module mem_port_req_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_LATENCY = 2
) (
  input  logic                         clka,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_we,
  input  logic [ADDR_WIDTH-1:0]        i_req_addr,
  input  logic [DATA_WIDTH-1:0]        i_req_data,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_din,
  input  logic [DATA_WIDTH-1:0]        i_mem_dout,
  output logic                         o_rd_valid,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         o_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                  fifo_q [FIFO_DEPTH];
  req_t                  fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  iss_valid_q, iss_valid_d;
  req_t                  iss_q, iss_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WR_LATENCY-1:0] whist_v_q, whist_v_d;
  logic [ADDR_WIDTH-1:0] whist_a_q [WR_LATENCY];
  logic [ADDR_WIDTH-1:0] whist_a_d [WR_LATENCY];
  logic                  busy_q, busy_d;

  req_t                  head;
  logic                  push;
  logic                  pop;
  logic                  hazard;

  // A head read loaded now is sampled one edge later; the issue-register write is
  // sampled one edge before it, and history entry k sits k+2 edges before it.
  always_comb begin
    head   = fifo_q[rd_ptr_q];
    hazard = 1'b0;
    if (!head.we) begin
      if ((WR_LATENCY > 1) && iss_valid_q && iss_q.we && (iss_q.addr == head.addr)) begin
        hazard = 1'b1;
      end
      for (int unsigned k = 0; k + 2 < WR_LATENCY; k++) begin
        if (whist_v_q[k] && (whist_a_q[k] == head.addr)) begin
          hazard = 1'b1;
        end
      end
    end
    push = i_req_valid && ready_q;
    pop  = (count_q != '0) && !hazard;
  end

  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    whist_a_d = whist_a_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{we: i_req_we, addr: i_req_addr, data: i_req_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d = count_d < CNT_W'(FIFO_DEPTH);

    iss_valid_d = pop;
    iss_d       = pop ? head : '0;

    // Both pipes advance every edge; slot 0 records what the memory samples now.
    rd_pipe_d = RD_LATENCY'({rd_pipe_q, (iss_valid_q && !iss_q.we)});
    whist_v_d = WR_LATENCY'({whist_v_q, (iss_valid_q && iss_q.we)});
    whist_a_d[0] = iss_q.addr;
    for (int unsigned i = 1; i < WR_LATENCY; i++) begin
      whist_a_d[i] = whist_a_q[i-1];
    end

    rd_valid_d = rd_pipe_q[RD_LATENCY-1];
    rd_data_d  = rd_pipe_q[RD_LATENCY-1] ? i_mem_dout : rd_data_q;

    busy_d = (count_d != '0) || iss_valid_d || (|rd_pipe_d) || (|whist_v_d);
  end

  always_ff @(posedge clka or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      rd_pipe_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      whist_v_q   <= '0;
      whist_a_q   <= '{default: '0};
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      whist_v_q   <= whist_v_d;
      whist_a_q   <= whist_a_d;
      busy_q      <= busy_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clka) begin
    fifo_q <= fifo_d;
  end

  assign o_req_ready  = ready_q;
  assign o_mem_en     = iss_valid_q;
  assign o_mem_we     = iss_q.we;
  assign o_mem_addr   = iss_q.addr;
  assign o_mem_din    = iss_q.data;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_fifo_count = count_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_mem_port_req_sequencer.sv
// Scoreboard bench for mem_port_req_sequencer with a latency-accurate memory model.
`timescale 1ns/1ps
module tb_mem_port_req_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 6;
  localparam int unsigned FD  = 4;
  localparam int unsigned RDL = 2;
  localparam int unsigned CW  = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          clka = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_we = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_data = '0;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_din;
  logic [DW-1:0] i_mem_dout;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic [CW-1:0] o_fifo_count;
  logic          o_busy;

  mem_port_req_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .RD_LATENCY(RDL), .WR_LATENCY(2)
  ) dut (
    .clka(clka), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
    .i_mem_dout(i_mem_dout), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_fifo_count(o_fifo_count), .o_busy(o_busy)
  );

  always #5 clka = ~clka;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data appears RDL edges after sampling, writes visible 2 edges after.
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] sh  [0:63];
  logic [DW-1:0] rdp [RDL];
  logic          wq_v = 1'b0;
  logic [AW-1:0] wq_a = '0;
  logic [DW-1:0] wq_d = '0;

  assign i_mem_dout = rdp[RDL-1];

  always @(posedge clka) begin
    if (o_mem_en && !o_mem_we) rdp[0] <= mem[o_mem_addr];
    for (int i = 1; i < RDL; i++) rdp[i] <= rdp[i-1];
    wq_v <= o_mem_en && o_mem_we;
    wq_a <= o_mem_addr;
    wq_d <= o_mem_din;
    if (wq_v) mem[wq_a] <= wq_d;
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  req_t iss_q [$];
  logic [DW-1:0] rd_q [$];
  int due_q [$];
  int rdv_edges [$];
  int last_wr_edge = 0;
  int last_rd_edge = 0;
  int last_acc_edge = 0;
  bit saw_full = 1'b0;

  // Output monitor: issue order, read-return data and timing, ready/count coherence.
  always @(negedge clka) begin
    req_t e;
    if (!i_rst) begin
      check_eq("ready_vs_count", 32'(o_req_ready), 32'(o_fifo_count < CW'(FD)));
      if (o_fifo_count == CW'(FD)) saw_full = 1'b1;
      if (o_mem_en) begin
        if (iss_q.size() == 0) begin
          check_eq("issue_unexpected", 32'(o_mem_en), 32'(0));
        end else begin
          e = iss_q.pop_front();
          check_eq("mem_we", 32'(o_mem_we), 32'(e.we));
          check_eq("mem_addr", 32'(o_mem_addr), 32'(e.addr));
          if (e.we) check_eq("mem_din", 32'(o_mem_din), 32'(e.data));
        end
        if (o_mem_we) begin
          last_wr_edge = cyc + 1;
        end else begin
          last_rd_edge = cyc + 1;
          due_q.push_back(cyc + 1 + RDL);
        end
      end
      if (o_rd_valid) begin
        rdv_edges.push_back(cyc);
        if (rd_q.size() == 0) check_eq("rd_unexpected", 32'(o_rd_valid), 32'(0));
        else check_eq("rd_data", 32'(o_rd_data), 32'(rd_q.pop_front()));
        if (due_q.size() != 0) check_eq("rd_time", 32'(cyc), 32'(due_q.pop_front()));
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        check_eq("rd_missing", 32'(o_rd_valid), 32'(1));
        void'(due_q.pop_front());
        if (rd_q.size() != 0) void'(rd_q.pop_front());
      end
    end
  end

  // Present one request from a negedge and hold it until accepted.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    bit   acc;
    int   budget;
    budget      = 200;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = a;
    i_req_data  = d;
    do begin
      acc = o_req_ready;
      if (acc) begin
        r.we = we; r.addr = a; r.data = d;
        iss_q.push_back(r);
        if (we) sh[a] = d;
        else rd_q.push_back(sh[a]);
        last_acc_edge = cyc + 1;
      end
      @(negedge clka);
      budget--;
    end while (!acc && budget > 0);
    if (!acc) check_eq("send_timeout", 32'(acc), 32'(1));
  endtask

  task automatic idle(input int n);
    i_req_valid = 1'b0;
    repeat (n) @(negedge clka);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = DW'(i * 7 + 16);
      sh[i]  = DW'(i * 7 + 16);
    end
    for (int i = 0; i < int'(RDL); i++) rdp[i] = '0;

    // Reset and idle
    repeat (3) @(negedge clka);
    i_rst = 1'b0;
    idle(3);
    check_eq("rst_ready", 32'(o_req_ready), 32'(1));
    check_eq("rst_mem_en", 32'(o_mem_en), 32'(0));
    check_eq("rst_rd_valid", 32'(o_rd_valid), 32'(0));
    check_eq("rst_count", 32'(o_fifo_count), 32'(0));
    check_eq("rst_busy", 32'(o_busy), 32'(0));

    // Read-after-write to the same address stalls one cycle
    send(1'b1, 6'd5, 8'hA5);
    n0 = last_acc_edge;
    check_eq("busy_active", 32'(o_busy), 32'(1));
    send(1'b0, 6'd5, 8'h00);
    idle(10);
    check_eq("raw_wr_edge", 32'(last_wr_edge), 32'(n0 + 2));
    check_eq("raw_rd_edge", 32'(last_rd_edge), 32'(n0 + 4));
    check_eq("raw_busy_idle", 32'(o_busy), 32'(0));

    // Alternating write/read pairs stall often enough to fill the FIFO
    for (int i = 0; i < 8; i++) begin
      send(1'b1, AW'(10 + i), DW'(8'h60 + i));
      send(1'b0, AW'(10 + i), 8'h00);
    end
    idle(20);
    check_eq("saw_full", 32'(saw_full), 32'(1));
    check_eq("fill_drained", 32'(o_fifo_count), 32'(0));

    // Back-to-back independent reads return on consecutive cycles
    rdv_edges.delete();
    send(1'b0, 6'd1, 8'h00);
    n0 = last_acc_edge;
    send(1'b0, 6'd2, 8'h00);
    send(1'b0, 6'd3, 8'h00);
    idle(10);
    check_eq("rd3_count", 32'(rdv_edges.size()), 32'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < rdv_edges.size()) check_eq("rd3_edge", 32'(rdv_edges[i]), 32'(n0 + 4 + i));
    end

    // Different addresses do not stall
    send(1'b1, 6'd7, 8'h77);
    n0 = last_acc_edge;
    send(1'b0, 6'd8, 8'h00);
    idle(10);
    check_eq("nohaz_wr_edge", 32'(last_wr_edge), 32'(n0 + 2));
    check_eq("nohaz_rd_edge", 32'(last_rd_edge), 32'(n0 + 3));

    // Reset while a read is in the return pipe
    send(1'b0, 6'd9, 8'h00);
    i_req_valid = 1'b0;
    @(negedge clka);
    check_eq("pre_rst_issue", 32'(o_mem_en), 32'(1));
    @(negedge clka);
    i_rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(o_req_ready), 32'(1));
    check_eq("mid_rst_mem_en", 32'(o_mem_en), 32'(0));
    check_eq("mid_rst_rd_valid", 32'(o_rd_valid), 32'(0));
    check_eq("mid_rst_count", 32'(o_fifo_count), 32'(0));
    check_eq("mid_rst_busy", 32'(o_busy), 32'(0));
    iss_q.delete();
    rd_q.delete();
    due_q.delete();
    repeat (2) @(negedge clka);
    i_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clka);
      check_eq("post_rst_rd_valid", 32'(o_rd_valid), 32'(0));
    end
    check_eq("post_rst_ready", 32'(o_req_ready), 32'(1));

    // Normal operation resumes after reset
    send(1'b1, 6'd9, 8'h3C);
    send(1'b0, 6'd9, 8'h00);
    idle(10);
    check_eq("end_rd_q_empty", 32'(rd_q.size()), 32'(0));
    check_eq("end_iss_q_empty", 32'(iss_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
